// File: rtl/gen1pkg.sv
// Shared definitions for the gen1 memory sequencer: FSM states, access kinds,
// error codes and the address-width selection.
package gen1pkg;

`ifdef GEN1_INT64
    localparam int GEN1_ADDR_WIDTH = 64;
`else
    localparam int GEN1_ADDR_WIDTH = 32;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XACK,
        ST_DONE,
        ST_ILLEGAL
    } gen1_state_e;

    typedef enum logic [1:0] {
        KIND_FETCH,
        KIND_READ,
        KIND_WRITE
    } gen1_kind_e;

    localparam logic [1:0] GEN1_ERR_OK      = 2'd0;
    localparam logic [1:0] GEN1_ERR_BUSX    = 2'd1;
    localparam logic [1:0] GEN1_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] GEN1_ERR_ILLEGAL = 2'd3;

    // Bus strobe pattern {memexec, memread, memwrite} for an access kind.
    function automatic logic [2:0] gen1_strobes(input gen1_kind_e kind);
        case (kind)
            KIND_FETCH: gen1_strobes = 3'b110;
            KIND_READ:  gen1_strobes = 3'b010;
            KIND_WRITE: gen1_strobes = 3'b001;
            default:    gen1_strobes = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/gen1memwdog.sv
// Loadable, saturating wait-state counter; o_expired flags the final allowed
// wait cycle so the sequencer can abort on that edge. LIMIT=0 never expires.
module gen1memwdog #(
    parameter int LIMIT = 255,
    localparam int CW = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_expired
);
    localparam logic [CW-1:0] MAXV = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != MAXV)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (LIMIT != 0) && (r_cnt >= LAST);

endmodule

// File: rtl/gen1memseq.sv
// Single-port memory sequencer: serialises fetch and data requests onto one
// bus with memready handshake, bus-exception acknowledge and timeout watchdog.
module gen1memseq
    import gen1pkg::*;
#(
    parameter int ADDR_WIDTH     = GEN1_ADDR_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ireq,
    input  logic [ADDR_WIDTH-1:0] iaddr,
    output logic [DATA_WIDTH-1:0] idata,
    output logic                  idone,
    input  logic                  dread,
    input  logic                  dwrite,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic [1:0]            errcode,
    output logic [ADDR_WIDTH-1:0] xaddr,
    output logic [DATA_WIDTH-1:0] xdout,
    input  logic [DATA_WIDTH-1:0] xdin,
    output logic                  memexec,
    output logic                  memread,
    output logic                  memwrite,
    input  logic                  memready,
    input  logic                  busx,
    output logic                  busxa
);
    gen1_state_e           r_state;
    gen1_kind_e            r_kind;
    logic [DATA_WIDTH-1:0] r_idata;
    logic [DATA_WIDTH-1:0] r_drdata;
    logic                  r_idone;
    logic                  r_ddone;
    logic [1:0]            r_err;
    logic [ADDR_WIDTH-1:0] r_xaddr;
    logic [DATA_WIDTH-1:0] r_xdout;
    logic                  r_memexec;
    logic                  r_memread;
    logic                  r_memwrite;
    logic                  r_busxa;

    logic                  w_expired;
    logic                  w_wd_clr;
    logic                  w_wd_en;
    logic                  w_finish;
    logic [1:0]            w_err;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_wd_clr = enable && (r_state == ST_IDLE);
    assign w_wd_en  = enable && (r_state == ST_WAIT) && !memready;

    gen1memwdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_wd_clr),
        .i_en       (w_wd_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_expired  (w_expired)
    );

    // Every path into DONE funnels through w_finish so the pulse, error code
    // and returned data are loaded in exactly one place.
    always_comb begin
        w_finish = 1'b0;
        w_err    = GEN1_ERR_OK;
        w_rdata  = '0;
        if (enable) begin
            case (r_state)
                ST_WAIT: begin
                    if (memready && !busx) begin
                        w_finish = 1'b1;
                        w_rdata  = xdin;
                    end else if (!memready && w_expired) begin
                        w_finish = 1'b1;
                        w_err    = GEN1_ERR_TIMEOUT;
                    end
                end
                ST_XACK: begin
                    if (!busx) begin
                        w_finish = 1'b1;
                        w_err    = GEN1_ERR_BUSX;
                    end
                end
                ST_ILLEGAL: begin
                    w_finish = 1'b1;
                    w_err    = GEN1_ERR_ILLEGAL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_kind     <= KIND_FETCH;
            r_idata    <= '0;
            r_drdata   <= '0;
            r_idone    <= 1'b0;
            r_ddone    <= 1'b0;
            r_err      <= GEN1_ERR_OK;
            r_xaddr    <= '0;
            r_xdout    <= '0;
            r_memexec  <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_busxa    <= 1'b0;
        end else if (enable) begin
            if (w_finish) begin
                r_state    <= ST_DONE;
                r_memexec  <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_busxa    <= 1'b0;
                r_err      <= w_err;
                if (r_kind == KIND_FETCH) begin
                    r_idone <= 1'b1;
                    r_idata <= w_rdata;
                end else begin
                    r_ddone  <= 1'b1;
                    r_drdata <= w_rdata;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (dread && dwrite) begin
                            r_kind  <= KIND_READ;
                            r_state <= ST_ILLEGAL;
                        end else if (dread || dwrite) begin
                            r_kind    <= dwrite ? KIND_WRITE : KIND_READ;
                            r_xaddr   <= daddr;
                            r_xdout   <= dwdata;
                            {r_memexec, r_memread, r_memwrite} <=
                                gen1_strobes(dwrite ? KIND_WRITE : KIND_READ);
                            r_state   <= ST_WAIT;
                        end else if (ireq) begin
                            r_kind    <= KIND_FETCH;
                            r_xaddr   <= iaddr;
                            {r_memexec, r_memread, r_memwrite} <= gen1_strobes(KIND_FETCH);
                            r_state   <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (memready && busx) begin
                            r_memexec  <= 1'b0;
                            r_memread  <= 1'b0;
                            r_memwrite <= 1'b0;
                            r_busxa    <= 1'b1;
                            r_state    <= ST_XACK;
                        end
                    end
                    ST_DONE: begin
                        r_idone <= 1'b0;
                        r_ddone <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign idata    = r_idata;
    assign idone    = r_idone;
    assign drdata   = r_drdata;
    assign ddone    = r_ddone;
    assign errcode  = r_err;
    assign xaddr    = r_xaddr;
    assign xdout    = r_xdout;
    assign memexec  = r_memexec;
    assign memread  = r_memread;
    assign memwrite = r_memwrite;
    assign busxa    = r_busxa;

endmodule
